mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the number of bus cycles without bus_ack before a transaction is aborted.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports inst_req input 1 fetch request; inst_addr input 32 fetch address.
REQ-005 SHALL have ports inst_rdata output 32 fetched word; inst_ack output 1 one-cycle completion pulse.
REQ-006 SHALL have ports data_req input 1 load/store request; data_we input 1 write; data_sel input 4 byte lanes; data_addr input 32; data_wdata input 32.
REQ-007 SHALL have ports data_rdata output 32 load word; data_ack output 1 one-cycle completion pulse.
REQ-008 SHALL have port stall_request  output  1  pipeline stall.
REQ-009 SHALL have ports bus_cyc output 1; bus_we output 1; bus_sel output 4; bus_addr output 32; bus_wdata output 32.
REQ-010 SHALL have ports bus_rdata input 32; bus_ack input 1 slave completion.
REQ-011 SHALL have port bus_err  output  1  one-cycle timeout pulse.

Function
REQ-012 SHALL implement FSM states IDLE, DATA, INST; all outputs except stall_request registered.
REQ-013 IDLE: data_req=1 and (inst_req=0 or last_grant=INST) -> DATA; else inst_req=1 -> INST; else stay IDLE.
REQ-014 last_grant SHALL record the requester of the most recently completed transaction, giving alternation when both requests are continuously high; reset value DATA.
REQ-015 On grant edge SHALL latch requester address/we/sel/wdata onto bus_*; set bus_cyc=1; INST grants drive bus_we=0, bus_sel=4'b1111, bus_wdata=0.
REQ-016 bus_* outputs SHALL remain stable while in DATA/INST.
REQ-017 bus_ack=1 in DATA/INST: next cycle bus_cyc=0, granted ack=1 for exactly one cycle, state IDLE.
REQ-018 On read completion SHALL load bus_rdata into granted rdata; on write completion data_rdata SHALL hold its value.
REQ-019 Latency: request sampled at edge N -> bus_cyc high from N+1; bus_ack at edge M -> ack high in cycle M+1; next grant no earlier than edge M+1 (bus_cyc low at least one cycle between transactions).
REQ-020 A 4-bit-or-wider wait counter SHALL clear on grant and increment each cycle in DATA/INST without bus_ack.
REQ-021 Counter reaching TIMEOUT SHALL abort: bus_err=1 and granted ack=1 for one cycle, rdata=0, bus_cyc=0, state IDLE.
REQ-022 bus_ack and timeout in the same cycle: ack wins, normal completion, bus_err=0.
REQ-023 bus_ack while IDLE SHALL be ignored.
REQ-024 Requester dropping req mid-transaction SHALL NOT abort; transaction completes and ack still pulses.
REQ-025 stall_request SHALL equal (data_req & ~data_ack) | (inst_req & ~inst_ack), combinational.

Reset
REQ-026 rst=1 at an edge SHALL force: state IDLE, last_grant DATA, counter 0, bus_cyc 0, bus_we 0, bus_sel 0, bus_addr 0, bus_wdata 0, inst_rdata 0, data_rdata 0, inst_ack 0, data_ack 0, bus_err 0.
REQ-027 Reset mid-transaction SHALL drop bus_cyc at that edge with no ack or bus_err pulse; a later bus_ack is ignored.

Verification
REQ-028 Fetch: inst_req=1, inst_addr=0x100, bus_ack one cycle after bus_cyc with bus_rdata=0x24020005 -> inst_rdata=0x24020005, inst_ack one cycle, bus_cyc low after.
REQ-029 Store: data_req=1, we=1, sel=4'b0100, addr=0x201, wdata=0x55555555 -> bus_we=1, bus_sel=4'b0100, bus_addr=0x201; data_ack pulses, data_rdata unchanged.
REQ-030 Contention: both req held high, immediate acks -> grant order DATA, INST, DATA, INST; stall_request high until each own ack.
REQ-031 Timeout: data read, bus_ack never asserted -> after 15 cycles bus_err and data_ack pulse together, data_rdata=0, bus_cyc=0.
REQ-032 Boundaries: bus_ack on 15th wait cycle -> normal completion, no bus_err; rst during DATA -> bus_cyc 0 next cycle, no ack.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Arbitrates an instruction-fetch port and a load/store port onto
//            one single-master memory bus. Both ports have equal priority and
//            alternate when both are requesting. The wait is bounded by a
//            timeout that aborts the cycle and pulses bus_err.
// Ports    : clk, rst (sync, active-high)
//            inst_req/inst_addr -> inst_rdata/inst_ack   fetch port
//            data_req/we/sel/addr/wdata -> data_rdata/data_ack  load/store port
//            stall_request      pipeline stall, combinational
//            bus_cyc/we/sel/addr/wdata -> bus_rdata/bus_ack, bus_err  bus side
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        stall_request,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  // The abort fires at the edge where the count would reach TIMEOUT, so a
  // bus_ack in the TIMEOUT-th wait cycle still completes normally.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant_inst;  // 0: data port completed last
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_data;
  logic             grant_inst;
  logic             done_ack;
  logic             done_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and grant/completion decode
  always_comb begin
    state_next   = state;
    grant_data   = 1'b0;
    grant_inst   = 1'b0;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (data_req && (!inst_req || last_grant_inst)) begin
          grant_data = 1'b1;
          state_next = DATA;
        end else if (inst_req) begin
          grant_inst = 1'b1;
          state_next = INST;
        end
      end
      DATA, INST: begin
        if (bus_ack) begin
          done_ack   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          done_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered bus and port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_inst <= 1'b0;
      wait_cnt        <= '0;
      bus_cyc         <= 1'b0;
      bus_we          <= 1'b0;
      bus_sel         <= 4'b0000;
      bus_addr        <= 32'h0;
      bus_wdata       <= 32'h0;
      inst_rdata      <= 32'h0;
      data_rdata      <= 32'h0;
      inst_ack        <= 1'b0;
      data_ack        <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      bus_err  <= 1'b0;

      if (grant_data) begin
        bus_cyc   <= 1'b1;
        bus_we    <= data_we;
        bus_sel   <= data_sel;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
        wait_cnt  <= '0;
      end else if (grant_inst) begin
        bus_cyc   <= 1'b1;
        bus_we    <= 1'b0;
        bus_sel   <= 4'b1111;
        bus_addr  <= inst_addr;
        bus_wdata <= 32'h0;
        wait_cnt  <= '0;
      end else if (done_ack) begin
        bus_cyc         <= 1'b0;
        last_grant_inst <= (state == INST);
        if (state == INST) begin
          inst_ack   <= 1'b1;
          inst_rdata <= bus_rdata;
        end else begin
          data_ack <= 1'b1;
          // A store leaves the last load value visible
          if (!bus_we) begin
            data_rdata <= bus_rdata;
          end
        end
      end else if (done_timeout) begin
        bus_cyc         <= 1'b0;
        bus_err         <= 1'b1;
        last_grant_inst <= (state == INST);
        if (state == INST) begin
          inst_ack   <= 1'b1;
          inst_rdata <= 32'h0;
        end else begin
          data_ack   <= 1'b1;
          data_rdata <= 32'h0;
        end
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Stall holds the pipeline until each pending requester sees its ack
  assign stall_request = (data_req & ~data_ack) | (inst_req & ~inst_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Scoreboard bench for mem_bus_arbiter. Stimulus pushes expected
//            bus grants and port responses into queues; independent monitors
//            pop and compare whenever the DUT opens a bus cycle or pulses an
//            ack. A small slave model answers after a programmable delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ack;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        stall_request;
  logic        bus_cyc;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .data_req(data_req), .data_we(data_we), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack),
    .stall_request(stall_request),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic        is_inst;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          ack_cycle = 0;       // wait cycle that gets bus_ack; 0 = never
  int          cyc_n = 0;
  logic        slave_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        rdata_from_addr = 1'b0;
  logic [31:0] slave_rdata = 32'h0;

  assign bus_ack = slave_ack | stray_ack;

  always @(negedge clk) begin
    if (bus_cyc === 1'b1) cyc_n++;
    else cyc_n = 0;
    slave_ack = (bus_cyc === 1'b1) && (ack_cycle != 0) && (cyc_n == ack_cycle);
    bus_rdata = rdata_from_addr ? {16'hCAFE, bus_addr[15:0]} : slave_rdata;
  end

  // ---------------- bus monitor ----------------
  bus_t cur_bus;
  logic prev_cyc = 1'b0;

  always @(negedge clk) begin
    if (bus_cyc === 1'b1) begin
      if (prev_cyc !== 1'b1) begin
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_grant: unexpected cycle addr 0x%08h", bus_addr);
          cur_bus = {bus_we, bus_sel, bus_addr, bus_wdata};
        end else begin
          cur_bus = exp_bus.pop_front();
        end
      end
      checks++;
      if ({bus_we, bus_sel, bus_addr, bus_wdata} !== cur_bus) begin
        errors++;
        $display("FAIL bus_fields: got we=%b sel=%b addr=0x%08h wdata=0x%08h expected we=%b sel=%b addr=0x%08h wdata=0x%08h",
                 bus_we, bus_sel, bus_addr, bus_wdata,
                 cur_bus.we, cur_bus.sel, cur_bus.addr, cur_bus.wdata);
      end
    end
    prev_cyc = bus_cyc;
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    resp_t e;
    if (inst_ack === 1'b1 || data_ack === 1'b1) begin
      checks++;
      if (exp_resp.size() == 0) begin
        errors++;
        $display("FAIL resp: unexpected ack inst=%b data=%b", inst_ack, data_ack);
      end else begin
        e = exp_resp.pop_front();
        if ((inst_ack && data_ack) || (inst_ack !== e.is_inst) || (bus_err !== e.err) ||
            ((inst_ack ? inst_rdata : data_rdata) !== e.rdata)) begin
          errors++;
          $display("FAIL resp: got inst=%b data=%b err=%b rdata=0x%08h expected inst=%b err=%b rdata=0x%08h",
                   inst_ack, data_ack, bus_err, inst_ack ? inst_rdata : data_rdata,
                   e.is_inst, e.err, e.rdata);
        end
      end
    end else if (bus_err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL bus_err_alone: bus_err=1 without ack");
    end
  end

  // Waits for the given port's ack, dropping its request in that cycle.
  task automatic wait_ack(input bit inst, output int hi);
    bit got;
    got = 1'b0;
    hi = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (inst ? inst_ack : data_ack) begin
        got = 1'b1;
        if (inst) inst_req = 1'b0;
        else data_req = 1'b0;
      end else if (bus_cyc) begin
        hi++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_wait: got no ack expected ack within 64 cycles (inst=%b)", inst);
    end else begin
      check("bus_cyc_at_ack", bus_cyc, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int acks;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_sel = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bus_cyc", bus_cyc, 0);
    check("rst_bus_fields", {bus_we, bus_sel, bus_wdata[26:0]}, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rdata", inst_rdata | data_rdata, 0);
    check("rst_strobes", {inst_ack, data_ack, bus_err, stall_request}, 0);
    rst = 1'b0;

    // Data read, acked in third wait cycle
    @(negedge clk);
    ack_cycle = 3; slave_rdata = 32'hDEADBEEF;
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h300, wdata: 32'h0});
    exp_resp.push_back('{is_inst: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF});
    data_req = 1'b1; data_we = 1'b0; data_sel = 4'b1111; data_addr = 32'h300; data_wdata = 32'h0;
    #1 check("stall_on_req", stall_request, 1);
    wait_ack(1'b0, hi);
    check("read_wait_cycles", hi, 3);

    // Store: data_rdata keeps the previous load value
    @(negedge clk);
    ack_cycle = 1; slave_rdata = 32'h12345678;
    exp_bus.push_back('{we: 1'b1, sel: 4'b0100, addr: 32'h201, wdata: 32'h55555555});
    exp_resp.push_back('{is_inst: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF});
    data_req = 1'b1; data_we = 1'b1; data_sel = 4'b0100; data_addr = 32'h201; data_wdata = 32'h55555555;
    wait_ack(1'b0, hi);
    check("store_rdata_hold", data_rdata, 32'hDEADBEEF);

    // Fetch
    @(negedge clk);
    ack_cycle = 1; slave_rdata = 32'h24020005;
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h100, wdata: 32'h0});
    exp_resp.push_back('{is_inst: 1'b1, err: 1'b0, rdata: 32'h24020005});
    inst_req = 1'b1; inst_addr = 32'h100;
    wait_ack(1'b1, hi);
    @(negedge clk);
    check("fetch_after", {bus_cyc, inst_ack}, 0);
    check("fetch_rdata", inst_rdata, 32'h24020005);

    // Contention: last completion was INST, so DATA goes first
    ack_cycle = 1; rdata_from_addr = 1'b1;
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h400, wdata: 32'h0});
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h500, wdata: 32'h0});
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h400, wdata: 32'h0});
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h500, wdata: 32'h0});
    exp_resp.push_back('{is_inst: 1'b0, err: 1'b0, rdata: 32'hCAFE0400});
    exp_resp.push_back('{is_inst: 1'b1, err: 1'b0, rdata: 32'hCAFE0500});
    exp_resp.push_back('{is_inst: 1'b0, err: 1'b0, rdata: 32'hCAFE0400});
    exp_resp.push_back('{is_inst: 1'b1, err: 1'b0, rdata: 32'hCAFE0500});
    data_req = 1'b1; data_we = 1'b0; data_sel = 4'b1111; data_addr = 32'h400; data_wdata = 32'h0;
    inst_req = 1'b1; inst_addr = 32'h500;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (inst_ack || data_ack) begin
        acks++;
        if (acks < 4) check("contention_stall", stall_request, 1);
        else begin
          data_req = 1'b0;
          inst_req = 1'b0;
        end
      end
    end
    check("contention_acks", acks, 4);
    #1 check("stall_released", stall_request, 0);
    rdata_from_addr = 1'b0;

    // Timeout: never acked
    @(negedge clk);
    ack_cycle = 0;
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h600, wdata: 32'h0});
    exp_resp.push_back('{is_inst: 1'b0, err: 1'b1, rdata: 32'h0});
    data_req = 1'b1; data_addr = 32'h600;
    wait_ack(1'b0, hi);
    check("timeout_wait_cycles", hi, 15);
    check("timeout_rdata", data_rdata, 0);
    @(negedge clk);
    check("timeout_err_pulse", {bus_err, data_ack}, 0);

    // Ack in 15th wait cycle wins; request dropped mid-transaction
    ack_cycle = 15; slave_rdata = 32'h0F0F0F0F;
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h604, wdata: 32'h0});
    exp_resp.push_back('{is_inst: 1'b0, err: 1'b0, rdata: 32'h0F0F0F0F});
    data_req = 1'b1; data_addr = 32'h604;
    for (int i = 0; i < 8 && bus_cyc !== 1'b1; i++) @(negedge clk);
    check("late_ack_granted", bus_cyc, 1);
    data_req = 1'b0;
    wait_ack(1'b0, hi);
    check("late_ack_wait_cycles", hi, 14);
    check("late_ack_rdata", data_rdata, 32'h0F0F0F0F);

    // Stray ack while idle
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", {bus_cyc, inst_ack, data_ack, bus_err}, 0);

    // Reset during DATA
    ack_cycle = 0;
    exp_bus.push_back('{we: 1'b0, sel: 4'b1111, addr: 32'h700, wdata: 32'h0});
    data_req = 1'b1; data_addr = 32'h700;
    repeat (3) @(negedge clk);
    check("pre_reset_cyc", bus_cyc, 1);
    data_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_cyc", bus_cyc, 0);
    check("reset_mid_strobes", {data_ack, inst_ack, bus_err}, 0);
    check("reset_mid_rdata", data_rdata, 0);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_quiet", {bus_cyc, data_ack, inst_ack, bus_err}, 0);

    repeat (3) @(negedge clk);
    check("exp_bus_drained", exp_bus.size(), 0);
    check("exp_resp_drained", exp_resp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
